// File: rtl/apb_pkg.sv
// Shared APB bus widths and the responder FSM state encoding.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;
    localparam int APB_NSLV   = 3;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t S_IDLE  = 2'd0;
    localparam apb_state_t S_WAIT  = 2'd1;
    localparam apb_state_t S_READY = 2'd2;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x 32 storage: async clear, one synchronous write port, one combinational read port.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [APB_DATA_W-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [APB_DATA_W-1:0]    rdata
);

    logic [APB_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB register memory: WAIT_STATES PREADY-low access cycles, then one PREADY cycle per transfer.
// Define APB_SLVERR_EN to add PSLVERR for out-of-range or misaligned addresses.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned           SLAVE_IDX   = 0,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned           DEPTH       = 64,
    parameter int unsigned           WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [APB_NSLV-1:0]   PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic [APB_DATA_W-1:0] PRDATA,
`ifdef APB_SLVERR_EN
    output logic                  PSLVERR,
`endif
    output logic                  PREADY
);

    localparam int unsigned         IDX_W    = $clog2(DEPTH);
    localparam logic [APB_ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + (APB_ADDR_W+1)'(4 * DEPTH);
    localparam logic [3:0]          WS_INIT  = 4'(WAIT_STATES);

    apb_state_t            state;
    logic [3:0]            count;
    logic [IDX_W-1:0]      idx_q;
    logic                  valid_q;
    logic                  write_q;
    logic [APB_DATA_W-1:0] wdata_q;

    logic                  sel;
    logic                  setup;
    logic                  access_ok;
    logic                  addr_ok;
    logic [IDX_W-1:0]      live_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  cur_write;
    logic                  cur_valid;
    logic                  enter_ready;
    logic                  we;
    logic [APB_DATA_W-1:0] mem_rdata;
    logic [APB_DATA_W-1:0] load_rdata;

    assign sel       = PSEL[SLAVE_IDX];
    assign setup     = sel && !PENABLE;
    assign access_ok = sel && PENABLE;

    // 33-bit compare so a window ending at 4 GiB cannot wrap.
    assign addr_ok  = ({1'b0, PADDR} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, PADDR} < END_ADDR) &&
                      (PADDR[1:0] == 2'b00);
    assign live_idx = IDX_W'((PADDR - BASE_ADDR) >> 2);

    // With zero wait states READY is entered on the setup edge, before the latches settle.
    assign rd_idx     = (state == S_IDLE) ? live_idx : idx_q;
    assign cur_write  = (state == S_IDLE) ? PWRITE   : write_q;
    assign cur_valid  = (state == S_IDLE) ? addr_ok  : valid_q;
    assign load_rdata = (cur_write || !cur_valid) ? '0 : mem_rdata;

    assign enter_ready = ((state == S_IDLE) && setup && (WAIT_STATES == 0)) ||
                         ((state == S_WAIT) && access_ok && (count == 4'd1));

    assign we     = (state == S_READY) && access_ok && write_q && valid_q;
    assign PREADY = (state == S_READY);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= S_IDLE;
            count   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (setup) begin
                        idx_q   <= live_idx;
                        valid_q <= addr_ok;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        if (WAIT_STATES == 0) begin
                            state <= S_READY;
                        end else begin
                            state <= S_WAIT;
                            count <= WS_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    count <= count - 4'd1;
                    if (!access_ok) begin
                        state <= S_IDLE;
                        count <= '0;
                    end else if (count == 4'd1) begin
                        state <= S_READY;
                    end
                end
                S_READY: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PRDATA <= '0;
        end else if (enter_ready) begin
            PRDATA <= load_rdata;
        end
    end

`ifdef APB_SLVERR_EN
    logic err_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            err_q <= 1'b0;
        end else if (enter_ready) begin
            err_q <= !cur_valid;
        end
    end

    assign PSLVERR = PREADY && err_q;
`endif

    apb_slave_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

endmodule
